// File: rtl/uart_tx_arbiter_pkg.sv
// uart_arb_pkg: shared definitions for the uart_tx arbiter.
//   - arb_state_t     : arbiter FSM state encoding
//   - DROP_TIMEOUT    : cycles uart_tx may stay idle after a start before
//                       the word is treated as dropped
//   - DEF_NUM_CLIENTS : default number of requesters
//   - DEF_WIDTH       : default data word width
//   - next_index()    : modulo-n increment used for the round-robin pointer
package uart_arb_pkg;

   localparam int DEF_NUM_CLIENTS = 4;
   localparam int DEF_WIDTH       = 8;
   localparam int DROP_TIMEOUT    = 3;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_IDLE = 2'd3
   } arb_state_t;

   function automatic int next_index(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: client-side and uart_tx-side signals of the arbiter.
//   Client side : req_i, data_i, lock_i (in), gnt_o, owner_o, busy_o (out)
//   uart_tx side: tx_idle_i (in), tx_data_o, tx_start_o, drop_o (out)
//   Debug       : dbg_state, dbg_rr_ptr (out)
//   slave modport = arbiter, master modport = clients + uart_tx.
//
// Handshake: a client raises req_i[k] with data_i[k] and holds both stable
// until it sees gnt_o[k] high for one cycle; that cycle the word has been
// captured into tx_data_o and the client may drop or re-raise its request.
// tx_start_o is a one-cycle pulse towards uart_tx, which answers by lowering
// tx_idle_i for the duration of the frame.
interface uart_tx_arbiter_if #(
   parameter int NUM_CLIENTS = uart_arb_pkg::DEF_NUM_CLIENTS,
   parameter int WIDTH       = uart_arb_pkg::DEF_WIDTH
);
   import uart_arb_pkg::*;

   localparam int OW = $clog2(NUM_CLIENTS);

   logic [NUM_CLIENTS-1:0]            req_i;
   logic [NUM_CLIENTS-1:0][WIDTH-1:0] data_i;
   logic [NUM_CLIENTS-1:0]            lock_i;
   logic [NUM_CLIENTS-1:0]            gnt_o;
   logic [OW-1:0]                     owner_o;
   logic                              busy_o;
   logic [WIDTH-1:0]                  tx_data_o;
   logic                              tx_start_o;
   logic                              tx_idle_i;
   logic                              drop_o;
   arb_state_t                        dbg_state;
   logic [OW-1:0]                     dbg_rr_ptr;

   modport slave (
      input  req_i, data_i, lock_i, tx_idle_i,
      output gnt_o, owner_o, busy_o, tx_data_o, tx_start_o, drop_o,
             dbg_state, dbg_rr_ptr
   );

   modport master (
      output req_i, data_i, lock_i, tx_idle_i,
      input  gnt_o, owner_o, busy_o, tx_data_o, tx_start_o, drop_o,
             dbg_state, dbg_rr_ptr
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority pick.
//   req       in  N      request vector
//   ptr       in  IW     highest-priority index; priority falls off
//                        cyclically from here
//   onehot    out N      one-hot winner (0 when no request)
//   index     out IW     winner index (0 when no request)
//   any_valid out 1      at least one request present
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] index,
   output logic          any_valid
);

   always_comb begin
      int cand;
      onehot    = '0;
      index     = '0;
      any_valid = 1'b0;
      cand      = 0;
      for (int i = 0; i < N; i++) begin
         cand = (int'(ptr) + i) % N;
         if (!any_valid && req[cand]) begin
            any_valid    = 1'b1;
            onehot[cand] = 1'b1;
            index        = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among NUM_CLIENTS requesters with
// round-robin arbitration, one word per grant.
//   clk_i  in  system clock, rising edge
//   rst_i  in  synchronous active-high reset
//   bus    uart_tx_arbiter_if.slave (client handshake, uart_tx control,
//          debug state/pointer)
// Optional feature: define UART_ARB_LOCK_EN to let a client holding
// lock_i keep the transmitter for back-to-back words; otherwise lock_i
// is ignored and arbitration is pure round-robin.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
   parameter int WIDTH       = DEF_WIDTH
) (
   input logic              clk_i,
   input logic              rst_i,
   uart_tx_arbiter_if.slave bus
);

   localparam int OW = $clog2(NUM_CLIENTS);

   arb_state_t             state, state_next;
   logic [OW-1:0]          rr_ptr, rr_ptr_next;
   logic [OW-1:0]          owner_next;
   logic [WIDTH-1:0]       tx_data_next;
   logic [NUM_CLIENTS-1:0] gnt_next;
   logic                   start_next;
   logic                   drop_next;
   logic [1:0]             drop_cnt, drop_cnt_next;
   // Set when the finishing owner still holds lock and request; only
   // meaningful while in IDLE.
   logic                   lock_hold, lock_hold_next;

   logic [NUM_CLIENTS-1:0] pick_onehot;
   logic [OW-1:0]          pick_index;
   logic                   pick_valid;

   rr_arbiter #(.N(NUM_CLIENTS)) u_rr (
      .req       (bus.req_i),
      .ptr       (rr_ptr),
      .onehot    (pick_onehot),
      .index     (pick_index),
      .any_valid (pick_valid)
   );

   // All outputs are registered: the comb block computes the value each
   // output must show in the state being entered.
   always_comb begin
      state_next     = state;
      rr_ptr_next    = rr_ptr;
      owner_next     = bus.owner_o;
      tx_data_next   = bus.tx_data_o;
      gnt_next       = '0;
      start_next     = 1'b0;
      drop_next      = 1'b0;
      drop_cnt_next  = drop_cnt;
      lock_hold_next = 1'b0;
      unique case (state)
         ST_IDLE: begin
            lock_hold_next = lock_hold;
            if (bus.tx_idle_i) begin
`ifdef UART_ARB_LOCK_EN
               if (lock_hold && bus.req_i[bus.owner_o]) begin
                  // Locked re-grant: same owner, pointer left where it is.
                  state_next     = ST_START;
                  tx_data_next   = bus.data_i[bus.owner_o];
                  gnt_next       = NUM_CLIENTS'(1) << bus.owner_o;
                  start_next     = 1'b1;
                  lock_hold_next = 1'b0;
               end else
`endif
               if (pick_valid) begin
                  state_next     = ST_START;
                  owner_next     = pick_index;
                  tx_data_next   = bus.data_i[pick_index];
                  gnt_next       = pick_onehot;
                  start_next     = 1'b1;
                  rr_ptr_next    = OW'(next_index(int'(pick_index), NUM_CLIENTS));
                  lock_hold_next = 1'b0;
               end
            end
         end
         ST_START: begin
            state_next    = ST_WAIT_BUSY;
            drop_cnt_next = '0;
         end
         ST_WAIT_BUSY: begin
            if (!bus.tx_idle_i) begin
               state_next = ST_WAIT_IDLE;
            end else if (drop_cnt == 2'(DROP_TIMEOUT - 1)) begin
               // uart_tx never acknowledged the start: give up on the word.
               state_next = ST_IDLE;
               drop_next  = 1'b1;
            end else begin
               drop_cnt_next = drop_cnt + 2'd1;
            end
         end
         ST_WAIT_IDLE: begin
            if (bus.tx_idle_i) begin
               state_next = ST_IDLE;
`ifdef UART_ARB_LOCK_EN
               lock_hold_next = bus.lock_i[bus.owner_o] && bus.req_i[bus.owner_o];
`endif
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= ST_IDLE;
         rr_ptr         <= '0;
         drop_cnt       <= '0;
         lock_hold      <= 1'b0;
         bus.gnt_o      <= '0;
         bus.tx_start_o <= 1'b0;
         bus.drop_o     <= 1'b0;
         bus.busy_o     <= 1'b0;
         bus.owner_o    <= '0;
         bus.tx_data_o  <= '0;
      end else begin
         state          <= state_next;
         rr_ptr         <= rr_ptr_next;
         drop_cnt       <= drop_cnt_next;
         lock_hold      <= lock_hold_next;
         bus.gnt_o      <= gnt_next;
         bus.tx_start_o <= start_next;
         bus.drop_o     <= drop_next;
         bus.busy_o     <= (state_next != ST_IDLE);
         bus.owner_o    <= owner_next;
         bus.tx_data_o  <= tx_data_next;
      end
   end

   assign bus.dbg_state  = state;
   assign bus.dbg_rr_ptr = rr_ptr;

endmodule
